pal_timing_generator: RTL
=========================

Name: pal_timing_generator

Overview:
- Free-running PAL 625-line interlaced raster timing source.
- Directly feeds the PAL composite DAC-sample generator: drives its subcarrierPhase, blank, sync, burst, oddFrame and oddLine inputs.
- Also exposes line/position info so the upstream pixel source can fetch Y/U/V in step.
- Clocked at 16 × fsc (70.9379 MHz); one clock = one subcarrier phase step (22.5°).

Parameters:
- LINE_CLOCKS, 4540, clocks per 64 µs line (= 283.75 subcarrier cycles; 25 Hz offset omitted)
- HSYNC_CLOCKS, 333, normal line sync width (4.7 µs)
- EQ_CLOCKS, 167, equalizing pulse width (2.35 µs)
- BROAD_CLOCKS, 1937, broad pulse width (half-line minus 4.7 µs)
- BURST_START, 397, burst start after line sync leading edge (5.6 µs)
- BURST_CLOCKS, 160, burst length (10 subcarrier cycles)
- ACTIVE_START, 745, first active clock of a line (10.5 µs)
- ACTIVE_END, 4423, first blanked clock after active video (front porch 1.65 µs)

Ports:
- phaseClock  in  1  16 × fsc clock
- resetN  in  1  asynchronous, active-low reset
- subcarrierPhase  out  4  subcarrier phase 0..15
- blank  out  1  1 outside active video
- sync  out  1  1 during any sync pulse (horizontal, equalizing, broad)
- burst  out  1  1 during colour-burst window
- oddFrame  out  1  1 in fields 1, 2, 5, 6, …
- oddLine  out  1  1 in lines 1, 2, 5, 6, … of the frame
- lineNumber  out  10  current frame line, 1..625
- hPos  out  13  clock position within line, 0..LINE_CLOCKS-1

Behaviour:
- Reset (asynchronous assert, released on next phaseClock edge) sets:
  - counters: hCount 0, halfLine h 0, fieldCount 0, phase 0
  - outputs: subcarrierPhase 0, blank 1, sync 0, burst 0, oddFrame 1, oddLine 1, lineNumber 1, hPos 0
- Counters:
  - hCount counts 0..LINE_CLOCKS-1, then wraps.
  - h counts half-lines 0..1249, incrementing at hCount 0 and at hCount 2270.
  - lineNumber = h/2 + 1.
  - phase increments by 1 every clock and wraps 15→0. It is never reset by line or field boundaries, so the phase at line start advances by 12 mod 16 each line.
  - fieldCount (2-bit) increments when h wraps to 0 and when h reaches 625.
  - oddFrame = ~fieldCount[1]; oddLine = ~(lineNumber-1)[1].
- Pipeline: all outputs are registered and mutually aligned, one clock after counter state. Every output for a given position appears on the same edge.
- Half-line class (p = position within half-line, 0..2269):
  - pre-equalizing: h 620..624 and 1245..1249; sync = p < EQ_CLOCKS
  - broad: h 0..4 and 625..629; sync = p < BROAD_CLOCKS
  - post-equalizing: h 5..9 and 630..634; sync = p < EQ_CLOCKS
  - normal: all other h; sync = (h even) && p < HSYNC_CLOCKS. Odd h inside normal lines has no sync.
- burst: asserted on BURST_START ≤ hCount < BURST_START+BURST_CLOCKS, only on lines 6..310 and 319..622.
- blank: 0 only when ACTIVE_START ≤ hCount < ACTIVE_END on lines 23..310 or 336..622. Blank is whole-line granular; half-line active lines are not supported.
- Simultaneous events: a sync or burst window never overlaps the active window. No priority logic is needed, but the bench checks that sync and burst are never both asserted and that blank=1 whenever sync or burst is asserted.
- Reset mid-frame: outputs jump immediately to reset values. Timing restarts from line 1, h 0 on the first edge after release. No partial pulse is stretched.

Decomposition:
- Package pal_timing_pkg holds the default parameter values, the half-line index boundaries (620, 625, 630, 635, 1245) and line ranges (6, 22/23, 310, 319, 336, 622).
- It also holds a 2-bit half-line class enum: NORMAL, PRE_EQ, BROAD, POST_EQ.
- One sub-module: pal_halfline_classifier, combinational, h → class + burstLine + activeLine.
- The top module holds the counters and output registers.

Test Plan:
1. Reset released → first edge gives lineNumber=1, sync=1 (broad); sync stays 1 for 1937 clocks, then 0 for 333 clocks; repeats for 5 half-lines.
2. Line 100 → sync high exactly hPos 0..332; burst high hPos 397..556; blank low hPos 745..4422; no sync at hPos 2270.
3. Half-line h=620 (line 311 start) → 167-clock sync pulses at hPos 0 and 2270; burst never asserted on line 311 or lines 1..5 and 311..318.
4. Over 4 consecutive fields → oddFrame sequence 1,1,0,0; oddLine over lines 1..6 is 1,1,0,0,1,1; lineNumber wraps 625→1.
5. Phase continuity → subcarrierPhase at hPos 0 of line n+1 equals (line n value + 12) mod 16; the frame-start value advances by 12 per frame.
6. Assert resetN low at line 200, hPos 1000 for 3 clocks → outputs at reset values immediately, asynchronously; after release the line 1 broad pulse starts on the next edge.

Source files
------------

// File: rtl/pal_timing_pkg.sv
// Shared constants and types for the PAL 625-line interlaced raster timing source.
// Half-line indices run 0..1249 across a frame; line numbers run 1..625.
package pal_timing_pkg;

   localparam int unsigned DEFAULT_LINE_CLOCKS  = 4540;
   localparam int unsigned DEFAULT_HSYNC_CLOCKS = 333;
   localparam int unsigned DEFAULT_EQ_CLOCKS    = 167;
   localparam int unsigned DEFAULT_BROAD_CLOCKS = 1937;
   localparam int unsigned DEFAULT_BURST_START  = 397;
   localparam int unsigned DEFAULT_BURST_CLOCKS = 160;
   localparam int unsigned DEFAULT_ACTIVE_START = 745;
   localparam int unsigned DEFAULT_ACTIVE_END   = 4423;

   // Half-line boundaries: broad 0..4, post-eq 5..9, pre-eq 620..624,
   // broad 625..629, post-eq 630..634, pre-eq 1245..1249.
   localparam logic [10:0] HALF_LINES  = 11'd1250;
   localparam logic [10:0] H_POST_EQ_1 = 11'd5;
   localparam logic [10:0] H_NORMAL_1  = 11'd10;
   localparam logic [10:0] H_PRE_EQ_1  = 11'd620;
   localparam logic [10:0] H_BROAD_2   = 11'd625;
   localparam logic [10:0] H_POST_EQ_2 = 11'd630;
   localparam logic [10:0] H_NORMAL_2  = 11'd635;
   localparam logic [10:0] H_PRE_EQ_2  = 11'd1245;

   localparam logic [9:0] BURST_FIRST_1  = 10'd6;
   localparam logic [9:0] BURST_LAST_1   = 10'd310;
   localparam logic [9:0] BURST_FIRST_2  = 10'd319;
   localparam logic [9:0] BURST_LAST_2   = 10'd622;
   localparam logic [9:0] ACTIVE_FIRST_1 = 10'd23;
   localparam logic [9:0] ACTIVE_LAST_1  = 10'd310;
   localparam logic [9:0] ACTIVE_FIRST_2 = 10'd336;
   localparam logic [9:0] ACTIVE_LAST_2  = 10'd622;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      PRE_EQ  = 2'd1,
      BROAD   = 2'd2,
      POST_EQ = 2'd3
   } halfLineClass_t;

endpackage

// File: rtl/pal_halfline_classifier.sv
// Combinational decode of a half-line index into its sync class and
// whether its frame line carries colour burst and active video.
module pal_halfline_classifier
   import pal_timing_pkg::*;
(
   input  logic [10:0]    halfLine,
   output halfLineClass_t lineClass,
   output logic           burstLine,
   output logic           activeLine
);

   logic [9:0] lineNum;

   always_comb begin
      lineNum   = halfLine[10:1] + 10'd1;
      lineClass = NORMAL;
      if ((halfLine >= H_PRE_EQ_1 && halfLine < H_BROAD_2) || halfLine >= H_PRE_EQ_2)
         lineClass = PRE_EQ;
      else if (halfLine < H_POST_EQ_1 || (halfLine >= H_BROAD_2 && halfLine < H_POST_EQ_2))
         lineClass = BROAD;
      else if (halfLine < H_NORMAL_1 || (halfLine >= H_POST_EQ_2 && halfLine < H_NORMAL_2))
         lineClass = POST_EQ;

      burstLine  = (lineNum >= BURST_FIRST_1 && lineNum <= BURST_LAST_1) ||
                   (lineNum >= BURST_FIRST_2 && lineNum <= BURST_LAST_2);
      activeLine = (lineNum >= ACTIVE_FIRST_1 && lineNum <= ACTIVE_LAST_1) ||
                   (lineNum >= ACTIVE_FIRST_2 && lineNum <= ACTIVE_LAST_2);
   end

endmodule

// File: rtl/pal_timing_generator.sv
// Free-running PAL interlaced raster timing source clocked at 16 x fsc.
// All outputs are registered together, one clock behind the counter state.
module pal_timing_generator
   import pal_timing_pkg::*;
#(
   parameter int unsigned LINE_CLOCKS  = DEFAULT_LINE_CLOCKS,
   parameter int unsigned HSYNC_CLOCKS = DEFAULT_HSYNC_CLOCKS,
   parameter int unsigned EQ_CLOCKS    = DEFAULT_EQ_CLOCKS,
   parameter int unsigned BROAD_CLOCKS = DEFAULT_BROAD_CLOCKS,
   parameter int unsigned BURST_START  = DEFAULT_BURST_START,
   parameter int unsigned BURST_CLOCKS = DEFAULT_BURST_CLOCKS,
   parameter int unsigned ACTIVE_START = DEFAULT_ACTIVE_START,
   parameter int unsigned ACTIVE_END   = DEFAULT_ACTIVE_END
)(
   input  logic        phaseClock,
   input  logic        resetN,
   output logic [3:0]  subcarrierPhase,
   output logic        blank,
   output logic        sync,
   output logic        burst,
   output logic        oddFrame,
   output logic        oddLine,
   output logic [9:0]  lineNumber,
   output logic [12:0] hPos
);

   localparam logic [12:0] LINE_LAST   = 13'(LINE_CLOCKS - 1);
   localparam logic [12:0] HALF_CLOCKS = 13'(LINE_CLOCKS / 2);
   localparam logic [12:0] HSYNC_W     = 13'(HSYNC_CLOCKS);
   localparam logic [12:0] EQ_W        = 13'(EQ_CLOCKS);
   localparam logic [12:0] BROAD_W     = 13'(BROAD_CLOCKS);
   localparam logic [12:0] BURST_FROM  = 13'(BURST_START);
   localparam logic [12:0] BURST_TO    = 13'(BURST_START + BURST_CLOCKS);
   localparam logic [12:0] ACTIVE_FROM = 13'(ACTIVE_START);
   localparam logic [12:0] ACTIVE_TO   = 13'(ACTIVE_END);
   localparam logic [10:0] H_LAST      = HALF_LINES - 11'd1;

   logic [12:0]    hCount, hCountNext;
   logic [10:0]    halfLine, halfLineNext;
   logic [1:0]     fieldCount, fieldCountNext;
   logic [3:0]     phase;
   logic [12:0]    halfPos;
   logic           syncNow, burstNow, blankNow;
   halfLineClass_t lineClass;
   logic           burstLine, activeLine;

   pal_halfline_classifier classifier (
      .halfLine   (halfLine),
      .lineClass  (lineClass),
      .burstLine  (burstLine),
      .activeLine (activeLine)
   );

   // The half-line index advances as hCount enters either half of a line.
   always_comb begin
      hCountNext     = (hCount == LINE_LAST) ? 13'd0 : hCount + 13'd1;
      halfLineNext   = halfLine;
      fieldCountNext = fieldCount;
      if (hCountNext == 13'd0 || hCountNext == HALF_CLOCKS) begin
         halfLineNext = (halfLine == H_LAST) ? 11'd0 : halfLine + 11'd1;
         if (halfLineNext == 11'd0 || halfLineNext == H_BROAD_2)
            fieldCountNext = fieldCount + 2'd1;
      end
   end

   always_comb begin
      halfPos = (hCount >= HALF_CLOCKS) ? hCount - HALF_CLOCKS : hCount;
      case (lineClass)
         PRE_EQ, POST_EQ: syncNow = halfPos < EQ_W;
         BROAD:           syncNow = halfPos < BROAD_W;
         default:         syncNow = !halfLine[0] && halfPos < HSYNC_W;
      endcase
      burstNow = burstLine && hCount >= BURST_FROM && hCount < BURST_TO;
      blankNow = !(activeLine && hCount >= ACTIVE_FROM && hCount < ACTIVE_TO);
   end

   // NOTE: counters and output registers share one reset so a mid-frame reset
   // drops every output at once and timing restarts cleanly at half-line 0.
   always_ff @(posedge phaseClock or negedge resetN) begin
      if (!resetN) begin
         hCount          <= '0;
         halfLine        <= '0;
         fieldCount      <= '0;
         phase           <= '0;
         subcarrierPhase <= '0;
         blank           <= 1'b1;
         sync            <= 1'b0;
         burst           <= 1'b0;
         oddFrame        <= 1'b1;
         oddLine         <= 1'b1;
         lineNumber      <= 10'd1;
         hPos            <= '0;
      end else begin
         hCount          <= hCountNext;
         halfLine        <= halfLineNext;
         fieldCount      <= fieldCountNext;
         phase           <= phase + 4'd1;
         subcarrierPhase <= phase;
         blank           <= blankNow;
         sync            <= syncNow;
         burst           <= burstNow;
         oddFrame        <= ~fieldCount[1];
         oddLine         <= ~halfLine[2];
         lineNumber      <= halfLine[10:1] + 10'd1;
         hPos            <= hCount;
      end
   end

endmodule
